// File: rtl/coord_entry_fsm_if.sv
// rtl/coord_entry_fsm_if.sv - button/ack inputs and cursor/selection outputs of one player's entry FSM
interface coord_entry_fsm_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_sel;
  logic       ack;
  logic [3:0] x_cur;
  logic [3:0] y_cur;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       ready;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, ack,
    output x_cur, y_cur, x_out, y_out, ready
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, ack,
    input  x_cur, y_cur, x_out, y_out, ready
  );
endinterface

// File: rtl/coord_entry_fsm.sv
// rtl/coord_entry_fsm.sv - cursor entry with edge/auto-repeat stepping and a ready/ack selection handshake
module coord_entry_fsm #(
  parameter int GRID_W     = 10,
  parameter int GRID_H     = 10,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic                clk,
  input  logic                reset,
  coord_entry_fsm_if.master   bus
);

  typedef enum logic [1:0] {EDIT, HOLD, COOL} state_t;

  localparam logic [3:0]  X_MAX     = 4'(GRID_W - 1);
  localparam logic [3:0]  Y_MAX     = 4'(GRID_H - 1);
  localparam logic [31:0] DLY       = 32'(REPEAT_DLY);
  localparam logic [31:0] RELOAD_AT = 32'(REPEAT_DLY + REPEAT_PER - 1);

  state_t      state_q, state_d;
  logic [3:0]  x_cur_q, x_cur_d, y_cur_q, y_cur_d;
  logic [3:0]  x_out_q, x_out_d, y_out_q, y_out_d;
  logic        ready_q, ready_d;
  logic [4:0]  prev_q, prev_d;
  logic [31:0] cnt_q [4];
  logic [31:0] cnt_d [4];

  logic [3:0]  dir_lvl;
  logic [3:0]  step_ev;
  logic        sel_rise;

  // Direction index: 0 up, 1 down, 2 left, 3 right. The hold count folds back to
  // DLY after each period so the tick compare stays a plain equality.
  always_comb begin
    dir_lvl  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    prev_d   = {bus.btn_sel, dir_lvl};
    sel_rise = bus.btn_sel & ~prev_q[4];
    step_ev  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = 32'd0;
      if (dir_lvl[i]) begin
        if (cnt_q[i] == RELOAD_AT) cnt_d[i] = DLY;
        else                       cnt_d[i] = cnt_q[i] + 32'd1;
      end
      step_ev[i] = dir_lvl[i] & (~prev_q[i] | (cnt_q[i] == DLY));
    end
  end

  always_comb begin
    state_d = state_q;
    x_cur_d = x_cur_q;
    y_cur_d = y_cur_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    ready_d = ready_q;
    case (state_q)
      EDIT: begin
        if (sel_rise) begin
          state_d = HOLD;
          ready_d = 1'b1;
          x_out_d = x_cur_q;
          y_out_d = y_cur_q;
        end else begin
          if (step_ev[0] && !step_ev[1])
            y_cur_d = (y_cur_q == 4'd0) ? Y_MAX : y_cur_q - 4'd1;
          else if (step_ev[1] && !step_ev[0])
            y_cur_d = (y_cur_q == Y_MAX) ? 4'd0 : y_cur_q + 4'd1;
          if (step_ev[2] && !step_ev[3])
            x_cur_d = (x_cur_q == 4'd0) ? X_MAX : x_cur_q - 4'd1;
          else if (step_ev[3] && !step_ev[2])
            x_cur_d = (x_cur_q == X_MAX) ? 4'd0 : x_cur_q + 4'd1;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          state_d = COOL;
          ready_d = 1'b0;
          x_out_d = 4'd0;
          y_out_d = 4'd0;
        end
      end
      COOL:    state_d = EDIT;
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EDIT;
      x_cur_q <= 4'd0;
      y_cur_q <= 4'd0;
      x_out_q <= 4'd0;
      y_out_q <= 4'd0;
      ready_q <= 1'b0;
      prev_q  <= 5'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      x_cur_q <= x_cur_d;
      y_cur_q <= y_cur_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      ready_q <= ready_d;
      prev_q  <= prev_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.x_cur = x_cur_q;
  assign bus.y_cur = y_cur_q;
  assign bus.x_out = x_out_q;
  assign bus.y_out = y_out_q;
  assign bus.ready = ready_q;

endmodule

// File: doc/coord_entry_fsm.md
# coord_entry_fsm

Player-side coordinate producer for the two-player board game. It turns debounced direction and select button levels into a cursor position on the grid. On select it latches the cursor and raises a level `ready` flag that feeds one of the ready inputs (`k_r` or `s_r`) of the downstream ready/coordinate checker. One instance is built per player; `ready` stays high until the consumer acknowledges it.

## Interface
- `GRID_W`, default 10: number of columns; x range is 0..GRID_W-1; must be 2..16.
- `GRID_H`, default 10: number of rows; y range is 0..GRID_H-1; must be 2..16.
- `REPEAT_DLY`, default 25_000_000: held-button cycles before auto-repeat starts.
- `REPEAT_PER`, default 5_000_000: cycles between auto-repeat steps; must be ≥1.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced, synchronous button levels.
- `btn_sel` in 1: debounced select level.
- `ack` in 1: consumer has taken the coordinates; only meaningful in HOLD.
- `x_cur`, `y_cur` out 4: live cursor position, for display.
- `x_out`, `y_out` out 4: latched selection; 0 when not in HOLD.
- `ready` out 1: selection pending; drives the checker's ready input.

## Operation
- **Reset values.** All outputs are 0. State = EDIT. Cursor = (0,0). Edge registers and the repeat counter are cleared.
- **Edge detection.** Each button has a registered previous level. A step event is one of:
  - a rising edge; or
  - an auto-repeat tick.
- **Auto-repeat.** A 32-bit hold counter runs per direction.
  - It is cleared whenever that button is low.
  - A tick fires when the count equals REPEAT_DLY, and every REPEAT_PER cycles after that, while the button stays high.
  - `btn_sel` has no auto-repeat: rising edge only.
- **States.**
  - **EDIT.**
    - up/down events decrement/increment y.
    - left/right events decrement/increment x.
    - Wrap-around:
      - 0 minus 1 → GRID_W-1 (or GRID_H-1);
      - max plus 1 → 0.
    - Opposing events in the same cycle (up+down, or left+right) cancel on that axis. An x step and a y step in the same cycle both apply.
    - A `btn_sel` rising edge goes to HOLD. It latches `x_out`/`y_out` from the cursor value before any same-cycle moves. Same-cycle moves are discarded.
  - **HOLD.**
    - `ready` = 1.
    - `x_out`/`y_out` are constant.
    - Cursor is frozen. Direction events and `sel` edges are ignored, but edge and hold registers keep tracking the buttons.
    - `ack` = 1 goes to COOL.
  - **COOL.**
    - Lasts exactly one cycle. `ready` = 0 and `x_out`/`y_out` = 0.
    - Returns to EDIT.
    - A `sel` edge during COOL is ignored. This prevents double submission from a bounce around ack.
- `ack` in EDIT or COOL has no effect.
- All arithmetic is on 4-bit values. The cursor never leaves the parameter range.

## Timing
- `ready`, `x_out`, `y_out` are registered outputs.
- A `sel` rise sampled at edge N gives `ready` = 1 with valid `x_out`/`y_out` from N+1.
- `ack` sampled at edge M gives `ready` = 0 from M+1. The earliest new `sel` is accepted at M+2.
- A single-cycle ack, or an ack held for many cycles, both produce one exit from HOLD.
- A direction rising edge at edge N is visible on `x_cur`/`y_cur` at N+1.
- Auto-repeat timing while a button stays high:
  - the first repeat step comes REPEAT_DLY cycles after the initial step;
  - later steps come every REPEAT_PER cycles.
- A button already high when EDIT is re-entered produces no rising edge. It may still auto-repeat if its hold count reaches the threshold.
- Reset asserted in any state returns all registers to reset values at the next edge. `ready` drops in that same cycle.

## Test plan
- **Reset and wrap-around.** Reset, then pulse `btn_left` once → `x_cur` = 9 (GRID_W=10). Then pulse `btn_right` → `x_cur` = 0. Then pulse `btn_up` twice → `y_cur` = 8.
- **Select and ack.** Move to (3,7), pulse `btn_sel` → `ready` = 1 with `x_out` = 3, `y_out` = 7 one cycle later. Direction pulses during HOLD leave the cursor at (3,7). Assert `ack` for 1 cycle → `ready` = 0 and `x_out`/`y_out` = 0 the next cycle.
- **Simultaneous events.** In one cycle raise `btn_up`, `btn_down` and `btn_right` from (5,5) → result is (6,5). Raising `btn_sel` together with `btn_right` at (6,5) → `x_out` = 6 and the cursor stays at (6,5).
- **Auto-repeat.** With REPEAT_DLY=8 and REPEAT_PER=3, hold `btn_right` for 20 cycles from x=0 → x = 1 + 1 + floor((20-1-8)/3) = 5 (initial step, first repeat, then 3 more at REPEAT_PER).
- **COOL window.** Pulse `sel` on the cycle after `ack` → ignored and `ready` stays 0. A `sel` two cycles after `ack` → accepted.
- **Reset mid-operation.** Assert `reset` while in HOLD with (2,4) latched → next cycle `ready` = 0, all outputs 0, cursor (0,0).
